// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
package cache_pkg;

  localparam int WORDS_PER_BLOCK     = 8;
  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Tag-array entry: six tag bits, valid set, LRU left for the cache to manage.
  function automatic logic [7:0] pack_tag(input logic [15:0] addr);
    return {addr[15:10], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Three-bit word counter with synchronous clear, count enable and a sticky
// done flag that sets when the count wraps past 7.
module fill_word_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] cnt,
  output logic       done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= 3'd0;
      done <= 1'b0;
    end else if (en) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) done <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: fetches an 8-word block and installs data and tag.
// Optional build macro CACHE_CRITICAL_WORD_FIRST_EN starts the fill at the missed word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [15:0] cache_addr,
  output logic [15:0] cache_data_in,
  output logic        write_tag_array,
  output logic [7:0]  tag_out
);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end

  fill_state_t state, state_next;
  logic [11:0] blk_addr;
  logic [2:0]  start_word;
  logic [2:0]  issue_cnt, recv_cnt;
  logic        issue_done, recv_done;
  logic        miss_take;
  logic        issue_en, recv_en;
  logic [2:0]  issue_word, recv_word;

  assign miss_take  = (state == IDLE) && miss_detected;
  assign issue_en   = (state == FILL) && !issue_done;
  assign recv_en    = (state == FILL) && memory_data_valid;
  assign issue_word = start_word + issue_cnt;
  assign recv_word  = start_word + recv_cnt;

  fill_word_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (miss_take),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .done (issue_done)
  );

  fill_word_counter u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (miss_take),
    .en   (recv_en),
    .cnt  (recv_cnt),
    .done (recv_done)
  );

  // The block completes on the 8th returned word, so the receive done flag is informational.
  logic unused_bits;
  assign unused_bits = ^{recv_done, miss_address[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      blk_addr   <= 12'h000;
      start_word <= 3'd0;
    end else begin
      state <= state_next;
      if (miss_take) begin
        blk_addr <= miss_address[15:4];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        start_word <= miss_address[3:1];
`else
        start_word <= 3'd0;
`endif
      end
    end
  end

  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    cache_addr       = 16'h0000;
    cache_data_in    = 16'h0000;
    write_tag_array  = 1'b0;
    tag_out          = 8'h00;
    case (state)
      IDLE: begin
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy      = 1'b1;
        cache_addr    = {blk_addr, recv_word, 1'b0};
        cache_data_in = memory_data;
        tag_out       = pack_tag({blk_addr, 4'h0});
        if (!issue_done) begin
          memory_read    = 1'b1;
          memory_address = {blk_addr, issue_word, 1'b0};
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          // Tag goes in alongside the last data word so the line becomes valid atomically.
          if (recv_cnt == 3'd7) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a request-ordered memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic [15:0] memory_data = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, cache_addr, cache_data_in;
  logic [7:0]  tag_out;

  cache_fill_fsm #(.MEM_LATENCY(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_addr        (cache_addr),
    .cache_data_in     (cache_data_in),
    .write_tag_array   (write_tag_array),
    .tag_out           (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
    logic [7:0]  tagv;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] a;
  } mreq_t;

  exp_t  req_q[$];
  exp_t  wr_q[$];
  mreq_t mq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;
  int busy_cnt = 0;
  int tag_cnt = 0;
  int tag_rel = 0;
  bit noise = 1'b0;
  bit irregular = 1'b0;
  int gap = 0;
  int gi = 0;
  int gaps[8] = '{1, 3, 2, 1, 2, 3, 1, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns words in request order, fixed 4-cycle latency or with gaps.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end else begin
      if (memory_read === 1'b1) mq.push_back('{cyc + 4, memory_address});
      memory_data_valid = 1'b0;
      memory_data       = 16'hDEAD;
      if (noise) begin
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        if (!irregular || gap == 0) begin
          memory_data_valid = 1'b1;
          memory_data       = mq[0].a ^ 16'h5A5A;
          void'(mq.pop_front());
          if (irregular) begin
            gap = gaps[gi % 8];
            gi++;
          end
        end else begin
          gap--;
        end
      end
    end
  end

  // Monitor: compare every request and write the DUT presents against the queues.
  always @(negedge clk) begin
    exp_t e;
    int rel;
    #1;
    rel = cyc - base;
    if (fsm_busy === 1'b1) busy_cnt++;
    if (write_tag_array === 1'b1) begin
      tag_cnt++;
      tag_rel = rel;
    end
    if (memory_read === 1'b1) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", {16'h0, memory_address}, 32'hFFFF_FFFF);
      end else begin
        e = req_q.pop_front();
        chk("req_addr", {16'h0, memory_address}, {16'h0, e.addr});
        if (e.cyc >= 0) chk("req_cycle", rel, e.cyc);
      end
    end
    if (write_data_array === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {16'h0, cache_addr}, 32'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", {16'h0, cache_addr}, {16'h0, e.addr});
        chk("wr_data", {16'h0, cache_data_in}, {16'h0, e.data});
        chk("wr_busy", {31'h0, fsm_busy}, 32'h1);
        chk("wr_tag_strobe", {31'h0, write_tag_array}, {31'h0, e.tag});
        if (e.cyc >= 0) chk("wr_cycle", rel, e.cyc);
        if (e.tag) chk("tag_out", {24'h0, tag_out}, {24'h0, e.tagv});
      end
    end else if (write_tag_array === 1'b1) begin
      chk("tag_without_write", 32'h1, 32'h0);
    end
  end

  function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    return a[3:1];
`else
    return 3'd0;
`endif
  endfunction

  task automatic push_fill(input logic [15:0] a, input int off, input logic [7:0] tagv,
                           input bit timed, input int nreq, input int nwr);
    logic [2:0]  w;
    logic [15:0] wa;
    for (int i = 0; i < 8; i++) begin
      w  = start_of(a) + 3'(i);
      wa = {a[15:4], w, 1'b0};
      if (i < nreq) req_q.push_back('{timed ? off + 1 + i : -1, wa, 16'h0, 1'b0, 8'h0});
      if (i < nwr) wr_q.push_back('{timed ? off + 5 + i : -1, wa, wa ^ 16'h5A5A, i == 7, tagv});
    end
  endtask

  task automatic start_miss(input logic [15:0] a);
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk);
    #1;
    base     = cyc - 1;
    busy_cnt = 0;
    @(negedge clk);
    miss_detected = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while ((req_q.size() > 0 || wr_q.size() > 0) && n < maxc) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("fill_complete_in_time", {31'h0, n < maxc}, 32'h1);
    @(negedge clk);
    #2;
    chk("idle_after_fill", {31'h0, fsm_busy}, 32'h0);
  endtask

  task automatic run_fill(input logic [15:0] a, input logic [7:0] tagv);
    int t0;
    t0 = tag_cnt;
    push_fill(a, 0, tagv, 1'b1, 8, 8);
    start_miss(a);
    wait_done(40);
    chk("busy_cycles", busy_cnt, 12);
    chk("tag_pulses", tag_cnt - t0, 1);
  endtask

  initial begin
    int t0;
    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'h0, fsm_busy}, 32'h0);
    chk("rst_mem_read", {31'h0, memory_read}, 32'h0);
    chk("rst_mem_addr", {16'h0, memory_address}, 32'h0);
    chk("rst_wr_data", {31'h0, write_data_array}, 32'h0);
    chk("rst_cache_addr", {16'h0, cache_addr}, 32'h0);
    chk("rst_cache_data", {16'h0, cache_data_in}, 32'h0);
    chk("rst_wr_tag", {31'h0, write_tag_array}, 32'h0);
    chk("rst_tag_out", {24'h0, tag_out}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_fill(16'h1234, 8'h12);
    run_fill(16'h123A, 8'h12);
    run_fill(16'hFFFE, 8'hFE);

    // Miss held high with a new address during the fill.
    t0 = tag_cnt;
    push_fill(16'h1234, 0, 8'h12, 1'b1, 8, 8);
    push_fill(16'h4000, 13, 8'h42, 1'b1, 8, 8);
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    @(posedge clk);
    #1;
    base     = cyc - 1;
    busy_cnt = 0;
    @(negedge clk);
    miss_address = 16'h4000;
    repeat (13) @(negedge clk);
    miss_detected = 1'b0;
    wait_done(40);
    chk("holdoff_busy_cycles", busy_cnt, 24);
    chk("holdoff_tag_pulses", tag_cnt - t0, 2);

    // Irregular return spacing.
    irregular = 1'b1;
    gap = 0;
    gi  = 0;
    t0  = tag_cnt;
    push_fill(16'h5672, 0, 8'h56, 1'b0, 8, 8);
    start_miss(16'h5672);
    wait_done(80);
    chk("irr_tag_pulses", tag_cnt - t0, 1);
    chk("irr_busy_until_tag", busy_cnt, tag_rel);
    irregular = 1'b0;

    // Valid noise while idle.
    @(negedge clk);
    noise = 1'b1;
    repeat (3) begin
      #1;
      chk("noise_busy", {31'h0, fsm_busy}, 32'h0);
      chk("noise_write", {31'h0, write_data_array}, 32'h0);
      @(negedge clk);
    end
    noise = 1'b0;
    @(negedge clk);

    // Reset during cycle 7 of a fill.
    t0 = tag_cnt;
    push_fill(16'h2468, 0, 8'h26, 1'b1, 7, 3);
    start_miss(16'h2468);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, fsm_busy}, 32'h0);
    chk("midrst_wr_tag", {31'h0, write_tag_array}, 32'h0);
    chk("midrst_mem_read", {31'h0, memory_read}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    chk("midrst_no_tag", tag_cnt - t0, 0);
    chk("midrst_req_q_empty", req_q.size(), 0);
    chk("midrst_wr_q_empty", wr_q.size(), 0);
    chk("midrst_idle", {31'h0, fsm_busy}, 32'h0);

    // Controller still works after the aborted fill.
    run_fill(16'h8010, 8'h82);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
